// File: rtl/simple_io_pkg.sv
// Shared types and constants for the SIMPLE core's I/O responders.
package simple_io_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned BYTES_PER_WORD = 2;

endpackage

// File: rtl/simple_sync_fifo.sv
// Single-clock FIFO; a push while full and a pop while empty are ignored.
module simple_sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/simple_out_port.sv
// OUT-instruction responder: buffers 16-bit words and shifts them out as two
// UART frames (8N1, high byte first).
module simple_out_port
  import simple_io_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       out_en,
  input  logic [DATA_W-1:0]          out_data,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic                       txd
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  tx_state_t         state_q;
  logic [DATA_W-1:0] hold_q;
  logic              byte_sel_q;
  logic [2:0]        bit_idx_q;
  logic [TW-1:0]     timer_q;
  logic              txd_q;
  logic              overflow_q;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty, pop;
  logic [7:0]        cur_byte;
  logic              bit_end, last_byte;

  simple_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_en),
    .pop   (pop),
    .din   (out_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop       = (state_q == StIdle) && !fifo_empty;
  assign cur_byte  = byte_sel_q ? hold_q[7:0] : hold_q[15:8];
  assign bit_end   = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_sel_q == 1'(BYTES_PER_WORD - 1));
  assign busy      = fifo_full;
  assign overflow  = overflow_q;
  assign txd       = txd_q;

  // txd is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= '0;
      timer_q    <= '0;
      txd_q      <= STOP_BIT;
    end else begin
      timer_q <= timer_q + TW'(1);
      unique case (state_q)
        StIdle: begin
          txd_q   <= STOP_BIT;
          timer_q <= '0;
          if (!fifo_empty) begin
            hold_q     <= fifo_dout;
            byte_sel_q <= 1'b0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          txd_q <= START_BIT;
          if (bit_end) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          txd_q <= cur_byte[bit_idx_q];
          if (bit_end) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) state_q <= StStop;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        StStop: begin
          txd_q <= STOP_BIT;
          if (bit_end) begin
            timer_q <= '0;
            if (!last_byte) begin
              byte_sel_q <= 1'b1;
              state_q    <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A dropped write takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      overflow_q <= 1'b0;
    else if (out_en && fifo_full)  overflow_q <= 1'b1;
    else if (clr_ovf)              overflow_q <= 1'b0;
  end

endmodule

// File: tb/tb_simple_out_port.sv
// Bench for simple_out_port: serial receiver + byte scoreboard, a vector table
// for buffering/overflow, and hand-written sequences for timing corners.
module tb_simple_out_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_en;
  logic [15:0] out_data;
  logic        clr_ovf;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        txd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb[$];
  logic       rx_busy  = 1'b0;
  logic       rx_abort = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic        en;
    logic        clr;
    logic        acc;
    logic [2:0]  exp_count;
    logic        exp_busy;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  simple_out_port #(
    .DATA_W       (16),
    .DEPTH        (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .out_en     (out_en),
    .out_data   (out_data),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .txd        (txd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    sb.push_back(w[15:8]);
    sb.push_back(w[7:0]);
  endtask

  always @(negedge rst) rx_abort = 1'b1;

  // Receiver: detect start at first negedge, then sample at the 2nd negedge of each bit.
  task automatic rx_frame();
    logic [7:0] b;
    logic       st, sp;
    rx_busy  = 1'b1;
    rx_abort = 1'b0;
    b        = '0;
    @(negedge clk);
    st = txd;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = txd;
    end
    repeat (4) @(negedge clk);
    sp = txd;
    if (!rx_abort) begin
      check("rx_start_bit", 32'(st), 32'd0);
      check("rx_stop_bit", 32'(sp), 32'd1);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected_byte: got %02h, expected no frame", b);
      end else begin
        check("rx_byte", 32'(b), 32'(sb.pop_front()));
      end
    end
    rx_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) rx_frame();
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || rx_busy) && n < 3000) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    repeat (5) tick();
    check({name, "_count"}, 32'(fifo_count), 32'd0);
    check({name, "_txd_idle"}, 32'(txd), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_low;

    tbl[0] = '{16'h0001, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{16'h0002, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[2] = '{16'h0003, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[3] = '{16'h0004, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    tbl[4] = '{16'h0005, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[6] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[7] = '{16'h0000, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};

    rst      = 1'b0;
    out_en   = 1'b0;
    out_data = '0;
    clr_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single word: start bit 2 clocks after strobe, 4 clocks wide, then bit0 of 0xA5.
    out_en = 1'b1; out_data = 16'hA55A; push_word(16'hA55A);
    tick();
    check("a55a_count_after_push", 32'(fifo_count), 32'd1);
    @(negedge clk); out_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("a55a_start_timing", 32'(txd), (k >= 2 && k <= 5) ? 32'd0 : 32'd1);
      if (k == 1) check("a55a_count_after_pop", 32'(fifo_count), 32'd0);
    end
    drain("a55a_drain");

    // Back-to-back writes, overflow and clear priority.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_en = tbl[i].en; out_data = tbl[i].data; clr_ovf = tbl[i].clr;
      if (tbl[i].acc) push_word(tbl[i].data);
      tick();
      check("tbl_count", 32'(fifo_count), 32'(tbl[i].exp_count));
      check("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
      check("tbl_ovf", 32'(overflow), 32'(tbl[i].exp_ovf));
    end
    @(negedge clk); out_en = 1'b0; clr_ovf = 1'b0;
    drain("burst_drain");

    // Write on the edge where the low-byte STOP ends: one IDLE cycle, then new start bit.
    @(negedge clk); out_en = 1'b1; out_data = 16'h1234; push_word(16'h1234);
    tick();
    @(negedge clk); out_en = 1'b0;
    repeat (80) tick();
    @(negedge clk); out_en = 1'b1; out_data = 16'hBEEF; push_word(16'hBEEF);
    tick();
    check("stopend_count_push", 32'(fifo_count), 32'd1);
    check("stopend_txd_stop", 32'(txd), 32'd1);
    @(negedge clk); out_en = 1'b0;
    tick();
    check("stopend_count_pop", 32'(fifo_count), 32'd0);
    check("stopend_txd_idle", 32'(txd), 32'd1);
    tick();
    check("stopend_txd_start", 32'(txd), 32'd0);
    drain("stopend_drain");

    // Push and pop on the same edge with two words buffered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_en = 1'b1; out_data = 16'h1111 * 16'(i + 1);
      push_word(16'h1111 * 16'(i + 1));
      tick();
    end
    check("pp_count_setup", 32'(fifo_count), 32'd2);
    @(negedge clk); out_en = 1'b0;
    repeat (79) tick();
    check("pp_count_before", 32'(fifo_count), 32'd2);
    @(negedge clk); out_en = 1'b1; out_data = 16'h4444; push_word(16'h4444);
    tick();
    check("pp_count_same_cycle", 32'(fifo_count), 32'd2);
    @(negedge clk); out_en = 1'b0;
    drain("pp_drain");

    // Reset in the middle of a DATA bit.
    @(negedge clk); out_en = 1'b1; out_data = 16'hC3C3;
    tick();
    @(negedge clk); out_data = 16'h0F0F;
    tick();
    @(negedge clk); out_en = 1'b0;
    repeat (8) tick();
    check("rst_mid_count_before", 32'(fifo_count), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    check("rst_no_residual_frame", 32'(saw_low), 32'd0);
    check("rst_count_after", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
